muldiv_seq: RTL
===============

# muldiv_seq

Iterative multiply/divide sequencer for the MIPS CPU. It owns the HI/LO registers and executes MULT, MULTU, DIV and DIVU over 32 cycles, reusing one 33-bit add/subtract path for every iteration. It sits beside the ALU in the execute stage. The control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request to begin an operation. Sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `DataA` input 32: multiplicand or dividend (rs). Captured on the accepting edge.
- `DataB` input 32: multiplier or divisor (rt). Captured on the accepting edge.
- `hi_we` input 1: MTHI write strobe.
- `lo_we` input 1: MTLO write strobe.
- `wr_data` input 32: data for MTHI/MTLO.
- `busy` output 1: operation in flight (CALC or FIX).
- `done` output 1: one-cycle pulse when HI/LO hold a new result.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States:
  - IDLE: `start` moves to CALC. Magnitudes and signs are latched, `cnt`=0, partial product/remainder cleared.
  - CALC: one iteration per cycle. `cnt` increments. At `cnt`=31 the next state is FIX.
  - FIX: sign correction. HI/LO are written, `done` is set, next state is IDLE.
- Signed ops (MULT, DIV) work on absolute values. For unsigned ops the magnitude is the raw operand.
- Multiply (shift-add):
  - Each iteration: if the multiplier LSB is 1, add the multiplicand into the upper 33 bits; shift the 64-bit product right by 1.
  - FIX: if MULT and sign(A)^sign(B), the 64-bit result is two's-complement negated. HI = [63:32], LO = [31:0].
- Divide (restoring):
  - Each iteration: shift the remainder:quotient pair left by 1 and trial-subtract the divisor in 33 bits.
  - If non-negative, keep the difference and set quotient bit 0. Otherwise restore.
  - FIX for DIV: quotient is negated if sign(A)^sign(B); remainder takes the sign of A. LO = quotient, HI = remainder.
- Divide by zero (DataB=0), DIV or DIVU: LO = 32'hFFFF_FFFF, HI = DataA, regardless of sign. Latency is unchanged.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0. No trap.
- `start` while `busy` is ignored. No queuing.
- `hi_we`/`lo_we` in IDLE write HI/LO on that edge. While `busy` they are ignored.
- `hi_we` and `lo_we` together write both registers with `wr_data`.
- `start` together with `hi_we`/`lo_we` in IDLE: the write takes effect and the operation starts. FIX later overwrites both registers.
- Reset (asynchronous, any state): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `cnt`=0. An in-flight operation is discarded.

## Timing
- `start` accepted at edge N:
  - `busy`=1 after edges N through N+32.
  - FIX entered at edge N+32.
  - Edge N+33 writes HI/LO. After that edge `done`=1 and `busy`=0 for one cycle.
- `done` is registered and falls after edge N+34.
- Earliest next accepted `start` is edge N+34. A back-to-back issue rate is one operation per 34 cycles.
- `hi`/`lo` are direct register outputs, with no combinational path from inputs.
- MTHI/MTLO latency: one edge.

## Configuration
- `MULDIV_EARLY_OUT_EN`:
  - Defined: in CALC for multiply, if the remaining (unshifted) multiplier bits are all zero, the block skips to FIX. The product is pre-aligned by a barrel shift of the remaining count. Latency becomes 2 + (index of highest set multiplier bit + 1) cycles, minimum 2. Division is unaffected.
  - Undefined: fixed 34-cycle latency for all ops.

## Structure
- Package `muldiv_pkg`:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum (S_IDLE, S_CALC, S_FIX)
  - ITER=32
  - DIV0_LO=32'hFFFF_FFFF
- Sub-module `muldiv_addsub`: combinational 33-bit adder/subtractor (sub select, result, borrow). It is shared by the multiply accumulate and the divide trial subtract. It is the only arithmetic instance apart from the FIX negators.

## Test plan
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF → HI=32'hFFFF_FFFE, LO=32'h0000_0001. `done` after edge N+33.
- MULT -7 × 3 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- DIV -7 / 2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIVU 100 / 0 → LO=32'hFFFF_FFFF, HI=100. DIV 32'h8000_0000 / -1 → LO=32'h8000_0000, HI=0.
- `start` pulsed at cycle 5 of an operation and `hi_we` with 32'hDEAD_BEEF while busy → both ignored; the result is that of the original op.
- `reset` asserted at iteration 17 → `busy`, `done`, `hi`, `lo` = 0 immediately. A new MULTU 3×4 then yields LO=12, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, states and constants
// for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER = 32;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  // Two's-complement magnitude when the operand is negative.
  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        neg
  );
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: 33-bit add/subtract shared by the
// multiply accumulate and the divide trial subtract.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_res,
  output logic         o_borrow
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_b;

  assign w_b   = i_sub ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_b}
               + {{W{1'b0}}, i_sub};

  assign o_res    = w_sum[W-1:0];
  assign o_borrow = i_sub & ~w_sum[W];

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-cycle MULT/MULTU/DIV/DIVU sequencer
// owning HI/LO. Option macro: MULDIV_EARLY_OUT_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_araw;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_is_div;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  logic [WIDTH:0]   w_as_a;
  logic [WIDTH:0]   w_as_b;
  logic [WIDTH:0]   w_as_res;
  logic             w_as_borrow;

  logic [WIDTH:0]   w_mul_up;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_q;
  logic [WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_nxt_acc;
  logic [WIDTH-1:0] w_nxt_q;
  logic [WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0] w_step_q;
  logic             w_eo;
  logic             w_eo_idle;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_f;
  logic [WIDTH-1:0]   w_quo_f;
  logic [WIDTH-1:0]   w_rem_f;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_sa     = w_signed & DataA[WIDTH-1];
  assign w_sb     = w_signed & DataB[WIDTH-1];
  assign w_mag_a  = mag32(DataA, w_sa);
  assign w_mag_b  = mag32(DataB, w_sb);

  // Multiply adds into the upper half; divide shifts
  // the remainder:quotient pair left and subtracts.
  assign w_as_a = r_is_div ? {r_acc, r_q[WIDTH-1]}
                           : {1'b0, r_acc};
  assign w_as_b = {1'b0, r_opnd};

  muldiv_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .i_a      (w_as_a),
    .i_b      (w_as_b),
    .i_sub    (r_is_div),
    .o_res    (w_as_res),
    .o_borrow (w_as_borrow)
  );

  assign w_mul_up  = r_q[0] ? w_as_res
                            : {1'b0, r_acc};
  assign w_mul_acc = w_mul_up[WIDTH:1];
  assign w_mul_q   = {w_mul_up[0], r_q[WIDTH-1:1]};

  assign w_div_acc = w_as_borrow ? w_as_a[WIDTH-1:0]
                                 : w_as_res[WIDTH-1:0];
  assign w_div_q   = {r_q[WIDTH-2:0], ~w_as_borrow};

  assign w_nxt_acc = r_is_div ? w_div_acc : w_mul_acc;
  assign w_nxt_q   = r_is_div ? w_div_q   : w_mul_q;

`ifdef MULDIV_EARLY_OUT_EN
  logic [4:0]         w_left;
  logic [WIDTH-1:0]   w_mask;
  logic [2*WIDTH-1:0] w_sh;

  // Once no multiplier bits remain, the rest of the
  // iterations are pure shifts; do them in one go.
  assign w_left = LAST - r_cnt;
  assign w_mask = (WIDTH'(1) << w_left) - WIDTH'(1);
  assign w_sh   = {w_mul_acc, w_mul_q} >> w_left;
  assign w_eo   = ~r_is_div
                & ((w_mul_q & w_mask) == '0);
  assign w_eo_idle = ~w_is_div & (w_mag_b == '0);

  assign w_step_acc = w_eo ? w_sh[2*WIDTH-1:WIDTH]
                           : w_nxt_acc;
  assign w_step_q   = w_eo ? w_sh[WIDTH-1:0]
                           : w_nxt_q;
`else
  assign w_eo       = 1'b0;
  assign w_eo_idle  = 1'b0;
  assign w_step_acc = w_nxt_acc;
  assign w_step_q   = w_nxt_q;
`endif

  assign w_prod   = {r_acc, r_q};
  assign w_prod_f = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_f  = r_neg_q ? (~r_q + 1'b1) : r_q;
  assign w_rem_f  = r_neg_r ? (~r_acc + 1'b1) : r_acc;

  // Sign-corrected results presented in FIX.
  always_comb begin
    w_fix_hi = w_prod_f[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_f[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_fix_hi = r_araw;
        w_fix_lo = DIV0_LO;
      end else begin
        w_fix_hi = w_rem_f;
        w_fix_lo = w_quo_f;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_state_nxt = w_eo_idle ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if ((r_cnt == LAST) || w_eo)
          w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and one iteration per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opnd   <= '0;
      r_araw   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_q      <= w_is_div ? w_mag_a : w_mag_b;
        r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
        r_araw   <= DataA;
        r_is_div <= w_is_div;
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_div0   <= w_is_div & (DataB == '0);
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= w_step_acc;
      r_q   <= w_step_q;
    end
  end

  // HI/LO: MTHI/MTLO only when idle, results in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if (r_state == S_IDLE) begin
      if (hi_we) r_hi <= wr_data;
      if (lo_we) r_lo <= wr_data;
    end
  end

  // Completion pulse follows the FIX cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= (r_state == S_FIX);
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
